card_deal_hand: RTL and testbench
=================================

# card_deal_hand

Dealing and hand-holding stage for the baccarat datapath. Sits directly upstream of the per-card 7-segment decoders: a free-running 1..13 card counter is sampled on each deal request and the value is stored into the next empty slot of the player or dealer hand. The block holds up to three 4-bit card codes per hand and presents them, plus running hand scores, to the display decoders and the win-decision logic. Codes follow the decoder encoding:
- 0 = blank
- 1 = ace
- 2..10 = pip value
- 11/12/13 = J/Q/K

## Interface
Parameters: none; all widths are fixed by the card encoding.

Ports:
- clk  in  1  system clock; all state changes on its rising edge
- reset  in  1  asynchronous, active-high reset
- deal_req  in  1  deal one card this cycle
- deal_to  in  1  target hand for deal_req: 0 = player, 1 = dealer
- new_round  in  1  synchronous clear of both hands
- pcard1, pcard2, pcard3  out  4 each  player slots, card codes (0 = empty)
- dcard1, dcard2, dcard3  out  4 each  dealer slots, card codes
- pcnt, dcnt  out  2 each  cards held per hand, 0..3
- pscore, dscore  out  4 each  baccarat hand score, 0..9
- deal_ack  out  1  one-cycle pulse: card stored
- deal_err  out  1  one-cycle pulse: request rejected because the target hand is full

## Operation
Card counter:
- 4-bit register, reset value 1.
- Increments on every rising edge; 13 wraps to 1. It never holds 0 or 14/15.
- Unaffected by new_round and by deal activity.

Deal (sampled on a rising edge, new_round low):
- deal_req=1 and target count < 3:
  - The counter value held before that edge is written to the target's slot[count+1].
  - Target count increments.
  - deal_ack=1 for the following cycle.
- deal_req=1 and target count = 3:
  - Slots and counts are unchanged.
  - deal_err=1 for the following cycle.
- deal_req=0: deal_ack=0 and deal_err=0.
- Only one hand is touched per request. The other hand's slots and count hold.

New round:
- new_round=1 at an edge sets all six slots to 0 and both counts to 0.
- new_round has priority over deal_req in the same cycle. The request is dropped, and deal_ack and deal_err stay 0.

Scoring (combinational from the slot registers):
- Card value = code for codes 1..9; 0 for codes 0, 10, 11, 12, 13.
- Score = (v1+v2+v3) mod 10. The sum is at most 27, so use a 5-bit intermediate.
- Empty slots contribute 0.

Reset (asynchronous, takes effect immediately):
- All slots = 0
- pcnt = dcnt = 0
- pscore = dscore = 0
- deal_ack = deal_err = 0
- Counter = 1

If reset is asserted mid-deal, the request is lost and no ack is produced after release.

## Timing
- Define edge n as the n-th rising edge after reset deasserts.
- Card captured at edge n = ((n-1) mod 13)+1.
- After edge n:
  - The slot and count are updated.
  - deal_ack/deal_err are high until edge n+1.
  - Scores reflect the new card in the same cycle as deal_ack.
- Back-to-back deal_req on consecutive edges is legal. Each is processed independently and acks are consecutive pulses.
- deal_to is sampled only with deal_req.
- Outputs are glitch-free registers, except pscore and dscore, which are combinational from registers.

## Test plan
- Reset/basic: hold reset, then release. All outputs are 0 and the counter is 1. Deal_req player at edge 5 gives pcard1=5, pcnt=1, pscore=5 and a single-cycle deal_ack.
- Wrap and face cards:
  - Dealer deals at edges 12, 13 and 14 give dcard1=12, dcard2=13, dcard3=1.
  - dscore=1 and dcnt=3.
- Full hand: a 4th dealer request at edge 20 produces deal_err for one cycle with no ack. Dealer slots stay 12, 13, 1, and player slots are unchanged.
- Score mod 10: player deals at edges 7, 8 and 9 give cards 7, 8, 9. pscore=4, since 24 mod 10. A 10 as a card contributes 0.
- Priority: new_round and deal_req asserted at the same edge clear all slots and counts to 0, scores to 0, and produce no ack and no err.
- Async reset mid-round: reset asserted between edges with cards held clears outputs immediately, without waiting for clk. After release, the first deal at edge 1 captures card 1.

Source files
------------

// File: rtl/card_deal_hand.sv
// Card dealing and hand-holding stage for the baccarat datapath.
// A free-running 1..13 counter is sampled on each deal request and stored
// into the next empty slot of the player or dealer hand. Hand scores are
// derived combinationally from the held slots.
module card_deal_hand (
    input  logic       clk,
    input  logic       reset,
    input  logic       deal_req,
    input  logic       deal_to,
    input  logic       new_round,
    output logic [3:0] pcard1,
    output logic [3:0] pcard2,
    output logic [3:0] pcard3,
    output logic [3:0] dcard1,
    output logic [3:0] dcard2,
    output logic [3:0] dcard3,
    output logic [1:0] pcnt,
    output logic [1:0] dcnt,
    output logic [3:0] pscore,
    output logic [3:0] dscore,
    output logic       deal_ack,
    output logic       deal_err
);

    logic [3:0] counter_q, counter_d;
    logic [3:0] pcard_q [3];
    logic [3:0] pcard_d [3];
    logic [3:0] dcard_q [3];
    logic [3:0] dcard_d [3];
    logic [1:0] pcnt_q, pcnt_d;
    logic [1:0] dcnt_q, dcnt_d;
    logic       ack_q, ack_d;
    logic       err_q, err_d;

    // Baccarat value of one card: pips count face value, 10 and faces count 0.
    function automatic logic [4:0] card_val(input logic [3:0] code);
        return (code >= 4'd1 && code <= 4'd9) ? {1'b0, code} : 5'd0;
    endfunction

    // Sum of three cards is at most 27, so two conditional subtractions do mod 10.
    function automatic logic [3:0] hand_score(input logic [3:0] c1,
                                              input logic [3:0] c2,
                                              input logic [3:0] c3);
        logic [4:0] s;
        s = card_val(c1) + card_val(c2) + card_val(c3);
        if (s >= 5'd20) begin
            s = s - 5'd20;
        end else if (s >= 5'd10) begin
            s = s - 5'd10;
        end
        return s[3:0];
    endfunction

    // Free-running card counter: 1..13, wrapping 13 -> 1.
    always_comb begin
        counter_d = (counter_q == 4'd13) ? 4'd1 : counter_q + 4'd1;
    end

    // Hand update: new_round clears both hands and wins over any deal request.
    always_comb begin
        pcard_d = pcard_q;
        dcard_d = dcard_q;
        pcnt_d  = pcnt_q;
        dcnt_d  = dcnt_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        if (new_round) begin
            for (int i = 0; i < 3; i++) begin
                pcard_d[i] = 4'd0;
                dcard_d[i] = 4'd0;
            end
            pcnt_d = 2'd0;
            dcnt_d = 2'd0;
        end else if (deal_req) begin
            if (!deal_to) begin
                if (pcnt_q != 2'd3) begin
                    for (int i = 0; i < 3; i++) begin
                        if (pcnt_q == 2'(i)) pcard_d[i] = counter_q;
                    end
                    pcnt_d = pcnt_q + 2'd1;
                    ack_d  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end else begin
                if (dcnt_q != 2'd3) begin
                    for (int i = 0; i < 3; i++) begin
                        if (dcnt_q == 2'(i)) dcard_d[i] = counter_q;
                    end
                    dcnt_d = dcnt_q + 2'd1;
                    ack_d  = 1'b1;
                end else begin
                    err_d = 1'b1;
                end
            end
        end
    end

    // State registers with asynchronous reset; counter restarts at 1.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            counter_q <= 4'd1;
            for (int i = 0; i < 3; i++) begin
                pcard_q[i] <= 4'd0;
                dcard_q[i] <= 4'd0;
            end
            pcnt_q <= 2'd0;
            dcnt_q <= 2'd0;
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            counter_q <= counter_d;
            pcard_q   <= pcard_d;
            dcard_q   <= dcard_d;
            pcnt_q    <= pcnt_d;
            dcnt_q    <= dcnt_d;
            ack_q     <= ack_d;
            err_q     <= err_d;
        end
    end

    // Outputs: slots, counts and pulses straight from registers; scores combinational.
    always_comb begin
        pcard1   = pcard_q[0];
        pcard2   = pcard_q[1];
        pcard3   = pcard_q[2];
        dcard1   = dcard_q[0];
        dcard2   = dcard_q[1];
        dcard3   = dcard_q[2];
        pcnt     = pcnt_q;
        dcnt     = dcnt_q;
        deal_ack = ack_q;
        deal_err = err_q;
        pscore   = hand_score(pcard_q[0], pcard_q[1], pcard_q[2]);
        dscore   = hand_score(dcard_q[0], dcard_q[1], dcard_q[2]);
    end

endmodule

// File: tb/tb_card_deal_hand.sv
// Self-checking bench for card_deal_hand against a queue-based hand model.
module tb_card_deal_hand;

    logic       clk = 1'b0;
    logic       reset;
    logic       deal_req;
    logic       deal_to;
    logic       new_round;
    logic [3:0] pcard1, pcard2, pcard3;
    logic [3:0] dcard1, dcard2, dcard3;
    logic [1:0] pcnt, dcnt;
    logic [3:0] pscore, dscore;
    logic       deal_ack, deal_err;

    int compared = 0;
    int mismatched = 0;

    // Reference model state
    int ph[$];
    int dh[$];
    bit exp_ack;
    bit exp_err;
    int edge_n;

    card_deal_hand dut (
        .clk       (clk),
        .reset     (reset),
        .deal_req  (deal_req),
        .deal_to   (deal_to),
        .new_round (new_round),
        .pcard1    (pcard1),
        .pcard2    (pcard2),
        .pcard3    (pcard3),
        .dcard1    (dcard1),
        .dcard2    (dcard2),
        .dcard3    (dcard3),
        .pcnt      (pcnt),
        .dcnt      (dcnt),
        .pscore    (pscore),
        .dscore    (dscore),
        .deal_ack  (deal_ack),
        .deal_err  (deal_err)
    );

    always #5 clk = ~clk;

    // Rising edges since reset was last released.
    always @(posedge clk or posedge reset) begin
        if (reset) edge_n <= 0;
        else       edge_n <= edge_n + 1;
    end

    function automatic int slot(input int h[$], input int i);
        return (i < h.size()) ? h[i] : 0;
    endfunction

    function automatic int score(input int h[$]);
        int s = 0;
        foreach (h[i]) s += (h[i] >= 1 && h[i] <= 9) ? h[i] : 0;
        return s % 10;
    endfunction

    function automatic logic [37:0] exp_vec();
        return {4'(slot(ph, 0)), 4'(slot(ph, 1)), 4'(slot(ph, 2)),
                4'(slot(dh, 0)), 4'(slot(dh, 1)), 4'(slot(dh, 2)),
                2'(ph.size()), 2'(dh.size()), 4'(score(ph)), 4'(score(dh)),
                exp_ack, exp_err};
    endfunction

    function automatic logic [37:0] dut_vec();
        return {pcard1, pcard2, pcard3, dcard1, dcard2, dcard3,
                pcnt, dcnt, pscore, dscore, deal_ack, deal_err};
    endfunction

    // One clock: drive at negedge, model the upcoming edge, return at next negedge.
    task automatic step(input bit req, input bit to, input bit nr);
        int card;
        deal_req  = req;
        deal_to   = to;
        new_round = nr;
        card = (edge_n % 13) + 1;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        if (nr) begin
            ph.delete();
            dh.delete();
        end else if (req) begin
            if (!to) begin
                if (ph.size() < 3) begin ph.push_back(card); exp_ack = 1'b1; end
                else exp_err = 1'b1;
            end else begin
                if (dh.size() < 3) begin dh.push_back(card); exp_ack = 1'b1; end
                else exp_err = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        deal_req  = 1'b0;
        new_round = 1'b0;
    endtask

    // Idle until the next step will land on edge n.
    task automatic idle_until(input int n);
        while (edge_n < n - 1) step(1'b0, 1'($urandom % 2), 1'b0);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        deal_req = 1'b0;
        deal_to = 1'b0;
        new_round = 1'b0;
        repeat (3) @(negedge clk);
        ph.delete(); dh.delete(); exp_ack = 0; exp_err = 0;
        compared++;
        if (dut_vec() !== 38'd0) begin
            mismatched++;
            $display("FAIL reset_state: got %h required %h", dut_vec(), 38'd0);
        end
        reset = 1'b0;
        idle_until(5);
        step(1'b1, 1'b0, 1'b0);
        compared++;
        if ({pcard1, pcnt, pscore, deal_ack, deal_err} !== {4'd5, 2'd1, 4'd5, 1'b1, 1'b0}) begin
            mismatched++;
            $display("FAIL first_deal_edge5: got card=%0d cnt=%0d score=%0d ack=%b err=%b",
                     pcard1, pcnt, pscore, deal_ack, deal_err);
        end
        step(1'b0, 1'b0, 1'b0);
        compared++;
        if (deal_ack !== 1'b0 || dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL ack_single_cycle: got %h required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_wrap();
        idle_until(12);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b0);
            compared++;
            if (dut_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL wrap_deal%0d: got %h required %h", i, dut_vec(), exp_vec());
            end
        end
        compared++;
        if ({dcard1, dcard2, dcard3, dscore, dcnt} !== {4'd12, 4'd13, 4'd1, 4'd1, 2'd3}) begin
            mismatched++;
            $display("FAIL wrap_face: got %0d %0d %0d score=%0d cnt=%0d required 12 13 1 1 3",
                     dcard1, dcard2, dcard3, dscore, dcnt);
        end
    endtask

    task automatic test_full();
        idle_until(20);
        step(1'b1, 1'b1, 1'b0);
        compared++;
        if ({deal_err, deal_ack, dcard1, dcard2, dcard3, pcard1, pcnt} !==
            {1'b1, 1'b0, 4'd12, 4'd13, 4'd1, 4'd5, 2'd1}) begin
            mismatched++;
            $display("FAIL full_hand: got err=%b ack=%b d=%0d,%0d,%0d p1=%0d pcnt=%0d",
                     deal_err, deal_ack, dcard1, dcard2, dcard3, pcard1, pcnt);
        end
        step(1'b0, 1'b0, 1'b0);
        compared++;
        if (deal_err !== 1'b0 || dut_vec() !== exp_vec()) begin
            mismatched++;
            $display("FAIL err_single_cycle: got %h required %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_score();
        step(1'b0, 1'b0, 1'b1);
        idle_until(33);  // edges 33..35 capture 7, 8, 9
        repeat (3) step(1'b1, 1'b0, 1'b0);
        compared++;
        if ({pcard1, pcard2, pcard3, pscore} !== {4'd7, 4'd8, 4'd9, 4'd4}) begin
            mismatched++;
            $display("FAIL score_mod10: got %0d %0d %0d score=%0d required 7 8 9 4",
                     pcard1, pcard2, pcard3, pscore);
        end
        step(1'b0, 1'b0, 1'b1);
        idle_until(49);  // edge 49 captures 10, edge 50 captures 11
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        compared++;
        if ({pcard1, pcard2, pscore, pcnt} !== {4'd10, 4'd11, 4'd0, 2'd2}) begin
            mismatched++;
            $display("FAIL ten_face_zero: got %0d %0d score=%0d cnt=%0d required 10 11 0 2",
                     pcard1, pcard2, pscore, pcnt);
        end
    endtask

    task automatic test_priority();
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1);
        compared++;
        if (dut_vec() !== 38'd0) begin
            mismatched++;
            $display("FAIL new_round_priority: got %h required %h", dut_vec(), 38'd0);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0, 1'b0);
            compared++;
            if (dut_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL back_to_back%0d: got %h required %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    task automatic test_async_reset();
        step(1'b1, 1'b1, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        ph.delete(); dh.delete(); exp_ack = 0; exp_err = 0;
        compared++;
        if (dut_vec() !== 38'd0) begin
            mismatched++;
            $display("FAIL async_reset_now: got %h required %h", dut_vec(), 38'd0);
        end
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 1'b0, 1'b0);
        compared++;
        if ({pcard1, pcnt, deal_ack} !== {4'd1, 2'd1, 1'b1}) begin
            mismatched++;
            $display("FAIL reset_edge1_card: got card=%0d cnt=%0d ack=%b required 1 1 1",
                     pcard1, pcnt, deal_ack);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 300; i++) begin
            step(1'(($urandom % 4) != 0), 1'($urandom % 2), 1'(($urandom % 12) == 0));
            compared++;
            if (dut_vec() !== exp_vec()) begin
                mismatched++;
                $display("FAIL random_step%0d: got %h required %h", i, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_wrap();
        test_full();
        test_score();
        test_priority();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
